// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store data memory: FSM states,
// RV32I load/store funct3 encodings, byte-enable, lane replication,
// load extension and access legality.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Loads and stores share funct3 codes, so each gets its own enum.
    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } load_f3_t;

    typedef enum logic [2:0] {
        SB = 3'b000,
        SH = 3'b001,
        SW = 3'b010
    } store_f3_t;

    localparam logic [7:0] ERR_CNT_MAX = 8'hFF;

    // Byte enables for a legal store; callers gate illegal accesses.
    function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] a);
        case (f3)
            SB:      store_be = 4'b0001 << a;
            SH:      store_be = 4'b0011 << a;
            SW:      store_be = 4'b1111;
            default: store_be = 4'b0000;
        endcase
    endfunction

    // Right-aligned store data replicated so every enabled lane sees it.
    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] w);
        case (f3)
            SB:      store_data = {4{w[7:0]}};
            SH:      store_data = {2{w[15:0]}};
            default: store_data = w;
        endcase
    endfunction

    // Lane select plus sign/zero extension of a loaded word.
    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] a,
                                                input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{a, 3'b000} +: 8];
        h = a[1] ? word[31:16] : word[15:0];
        case (f3)
            LB:      load_extend = {{24{b[7]}}, b};
            LBU:     load_extend = {24'h0, b};
            LH:      load_extend = {{16{h[15]}}, h};
            LHU:     load_extend = {16'h0, h};
            LW:      load_extend = word;
            default: load_extend = 32'h0;
        endcase
    endfunction

    // Misaligned access or unsupported funct3 for the given direction.
    function automatic logic access_err(input logic we, input logic [2:0] f3, input logic [1:0] a);
        access_err = 1'b1;
        if (we) begin
            case (f3)
                SB:      access_err = 1'b0;
                SH:      access_err = a[0];
                SW:      access_err = (a != 2'b00);
                default: access_err = 1'b1;
            endcase
        end else begin
            case (f3)
                LB, LBU: access_err = 1'b0;
                LH, LHU: access_err = a[0];
                LW:      access_err = (a != 2'b00);
                default: access_err = 1'b1;
            endcase
        end
    endfunction

endpackage

// File: rtl/lsu_sram.sv
// Word-addressed single-port RAM with per-byte write enable and a
// registered read port. Contents are never reset.
module lsu_sram #(
    parameter int IDX_W     = 7,
    parameter     INIT_FILE = ""
) (
    input  logic             clk,
    input  logic [IDX_W-1:0] addr,
    input  logic [3:0]       be,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    localparam int DEPTH = 2 ** IDX_W;

    logic [31:0] mem [DEPTH];

    // Byte-granular write and read-before-write registered read.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/lsu_datamem.sv
// Load/store data memory: accepts one RV32I load/store at a time, runs a
// fixed IDLE -> ACCESS -> RESP sequence and holds the response until taken.
module lsu_datamem
    import lsu_pkg::*;
#(
    parameter int ADDR_W    = 9,
    parameter int DATA_W    = 32,
    parameter     INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [7:0]        err_cnt
);

    state_t            state, state_nx;
    logic              accept;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [2:0]        f3_q;
    logic [31:0]       wdata_q;
    logic              err_q;
    logic [3:0]        ram_be;
    logic [31:0]       ram_rdata;

    assign accept = req_valid && req_ready;

    // State register; reset discards any in-flight request or response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next state and handshake; RESP waits one fill cycle for rsp_valid.
    always_comb begin
        state_nx  = state;
        req_ready = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nx = ACCESS;
            end
            ACCESS:  state_nx = RESP;
            RESP:    if (rsp_valid && rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Capture request fields and legality on acceptance (data path, no reset).
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q  <= req_addr;
            we_q    <= req_we;
            f3_q    <= req_funct3;
            wdata_q <= req_wdata;
            err_q   <= access_err(req_we, req_funct3, req_addr[1:0]);
        end
    end

    // Writes only happen on the ACCESS edge, so a reset before it aborts them.
    assign ram_be = (state == ACCESS && we_q && !err_q) ? store_be(f3_q, addr_q[1:0]) : 4'b0000;

    lsu_sram #(
        .IDX_W     (ADDR_W - 2),
        .INIT_FILE (INIT_FILE)
    ) u_sram (
        .clk   (clk),
        .addr  (addr_q[ADDR_W-1:2]),
        .be    (ram_be),
        .wdata (store_data(f3_q, wdata_q)),
        .rdata (ram_rdata)
    );

    // Response registers: filled once in RESP, held until the handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else if (state == RESP && !rsp_valid) begin
            rsp_valid <= 1'b1;
            rsp_err   <= err_q;
            rsp_rdata <= (we_q || err_q) ? 32'h0 : load_extend(f3_q, addr_q[1:0], ram_rdata);
        end else if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end
    end

    // Saturating count of requests rejected at acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                          err_cnt <= 8'h0;
        else if (accept && access_err(req_we, req_funct3, req_addr[1:0]) &&
                 err_cnt != ERR_CNT_MAX)                     err_cnt <= err_cnt + 8'h1;
    end

endmodule

// File: tb/tb_lsu_datamem.sv
// Directed bench for lsu_datamem with hand-computed expected values.
module tb_lsu_datamem;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [8:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [7:0]  err_cnt;

    int n_checks = 0;
    int n_errors = 0;

    lsu_datamem dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .err_cnt    (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // One request; hold>0 keeps rsp_ready low that many cycles after rsp_valid.
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [8:0] addr,
                          input logic [31:0] wd, input int hold, input logic [31:0] exp_hold,
                          output logic [31:0] rd, output logic er, output int lat);
        int w;
        rsp_ready  = (hold == 0);
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        req_valid  = 1'b1;
        w = 0;
        while (!req_ready && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        rd = rsp_rdata;
        er = rsp_err;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("stall_rsp_valid", 32'(rsp_valid), 32'd1);
            check("stall_rsp_rdata", rsp_rdata, exp_hold);
            check("stall_req_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat;

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = '0;
        req_wdata  = '0;
        rsp_ready  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        check("rst_rsp_err",   32'(rsp_err), 32'd0);
        check("rst_err_cnt",   32'(err_cnt), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Word store and load-back with latency.
        do_req(1'b1, 3'b010, 9'h010, 32'hDEADBEEF, 0, 32'h0, rd, er, lat);
        check("sw_err", 32'(er), 32'd0);
        check("sw_rdata", rd, 32'h0);
        check("sw_lat", 32'(lat), 32'd2);
        do_req(1'b0, 3'b010, 9'h010, 32'h0, 0, 32'h0, rd, er, lat);
        check("lw_rdata", rd, 32'hDEADBEEF);
        check("lw_err", 32'(er), 32'd0);
        check("lw_lat", 32'(lat), 32'd2);

        // Byte store into lane 3, then signed/unsigned loads.
        do_req(1'b1, 3'b000, 9'h013, 32'h00000080, 0, 32'h0, rd, er, lat);
        check("sb_err", 32'(er), 32'd0);
        do_req(1'b0, 3'b000, 9'h013, 32'h0, 0, 32'h0, rd, er, lat);
        check("lb_13", rd, 32'hFFFFFF80);
        do_req(1'b0, 3'b100, 9'h013, 32'h0, 0, 32'h0, rd, er, lat);
        check("lbu_13", rd, 32'h00000080);
        do_req(1'b0, 3'b010, 9'h010, 32'h0, 0, 32'h0, rd, er, lat);
        check("lw_after_sb", rd, 32'h80ADBEEF);
        do_req(1'b0, 3'b001, 9'h012, 32'h0, 0, 32'h0, rd, er, lat);
        check("lh_12", rd, 32'hFFFF80AD);
        do_req(1'b0, 3'b101, 9'h012, 32'h0, 0, 32'h0, rd, er, lat);
        check("lhu_12", rd, 32'h000080AD);
        do_req(1'b0, 3'b000, 9'h010, 32'h0, 0, 32'h0, rd, er, lat);
        check("lb_10", rd, 32'hFFFFFFEF);

        // Misaligned halfword store is rejected without writing.
        do_req(1'b1, 3'b001, 9'h011, 32'h00001234, 0, 32'h0, rd, er, lat);
        check("sh_mis_err", 32'(er), 32'd1);
        check("sh_mis_rdata", rd, 32'h0);
        check("sh_mis_cnt", 32'(err_cnt), 32'd1);
        do_req(1'b0, 3'b010, 9'h010, 32'h0, 0, 32'h0, rd, er, lat);
        check("lw_after_sh", rd, 32'h80ADBEEF);
        check("lw_after_sh_err", 32'(er), 32'd0);

        // Illegal funct3 for load and store.
        do_req(1'b0, 3'b011, 9'h010, 32'h0, 0, 32'h0, rd, er, lat);
        check("ld_f3_011_err", 32'(er), 32'd1);
        do_req(1'b1, 3'b100, 9'h010, 32'h55555555, 0, 32'h0, rd, er, lat);
        check("st_f3_100_err", 32'(er), 32'd1);
        check("err_cnt_3", 32'(err_cnt), 32'd3);
        do_req(1'b0, 3'b010, 9'h010, 32'h0, 0, 32'h0, rd, er, lat);
        check("lw_after_bad_st", rd, 32'h80ADBEEF);

        // Back-pressure: response held for 5 cycles.
        do_req(1'b0, 3'b010, 9'h010, 32'h0, 5, 32'h80ADBEEF, rd, er, lat);
        check("stall_first_rdata", rd, 32'h80ADBEEF);
        check("after_hs_rsp_valid", 32'(rsp_valid), 32'd0);
        check("after_hs_req_ready", 32'(req_ready), 32'd1);

        // Known value at 0x020 before the reset-abort test.
        do_req(1'b1, 3'b010, 9'h020, 32'h11223344, 0, 32'h0, rd, er, lat);
        do_req(1'b0, 3'b010, 9'h020, 32'h0, 0, 32'h0, rd, er, lat);
        check("lw_20_init", rd, 32'h11223344);

        // Error counter saturation.
        for (int i = 0; i < 300; i++) begin
            do_req(1'b0, 3'b010, 9'h001, 32'h0, 0, 32'h0, rd, er, lat);
        end
        check("sat_err", 32'(er), 32'd1);
        check("sat_err_cnt", 32'(err_cnt), 32'd255);

        // Reset during ACCESS aborts the store.
        req_we     = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 9'h020;
        req_wdata  = 32'hFFFFFFFF;
        req_valid  = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        check("abort_rsp_rdata", rsp_rdata, 32'h0);
        check("abort_rsp_err", 32'(rsp_err), 32'd0);
        check("abort_err_cnt", 32'(err_cnt), 32'd0);
        check("abort_req_ready", 32'(req_ready), 32'd1);
        #2;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("abort_idle_valid", 32'(rsp_valid), 32'd0);
        do_req(1'b0, 3'b010, 9'h020, 32'h0, 0, 32'h0, rd, er, lat);
        check("abort_lw_20", rd, 32'h11223344);
        check("abort_lw_lat", 32'(lat), 32'd2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/lsu_datamem.md
LSU_DATAMEM -- requirements
Module: lsu_datamem

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 9, meaning byte-address width; word depth = 2**(ADDR_W-2).
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning word width; only 32 is legal.
REQ-003 The block SHALL have parameter INIT_FILE, default "", meaning an optional hex preload file; empty means no preload.
REQ-004 The block SHALL have port clk  in  1  meaning the sole clock; all state updates on the rising edge.
REQ-005 The block SHALL have port rst_n  in  1  meaning the reset, which is asynchronous and active-low.
REQ-006 The block SHALL have port req_valid  in  1  meaning a request is offered.
REQ-007 The block SHALL have port req_ready  out  1  meaning the block can accept a request.
REQ-008 The block SHALL have port req_we  in  1  meaning 1 = store, 0 = load.
REQ-009 The block SHALL have port req_funct3  in  3  meaning the RV32I load/store funct3.
REQ-010 The block SHALL have port req_addr  in  ADDR_W  meaning the byte address.
REQ-011 The block SHALL have port req_wdata  in  32  meaning store data, right-aligned.
REQ-012 The block SHALL have port rsp_valid  out  1  meaning a response is available.
REQ-013 The block SHALL have port rsp_ready  in  1  meaning the consumer accepts the response.
REQ-014 The block SHALL have port rsp_rdata  out  32  meaning the extended load data; 0 for stores and errors.
REQ-015 The block SHALL have port rsp_err  out  1  meaning a misaligned or illegal-funct3 access.
REQ-016 The block SHALL have port err_cnt  out  8  meaning a saturating count of errored requests.

Function
REQ-017 The FSM SHALL have states IDLE, ACCESS and RESP; req_ready SHALL be 1 only in IDLE.
REQ-018 The FSM SHALL make these transitions:
- IDLE->ACCESS on req_valid&&req_ready; request fields are captured on that edge.
- ACCESS->RESP unconditionally.
- RESP->IDLE on rsp_ready.
REQ-019 The block SHALL have fixed latency: a request accepted at edge T gives rsp_valid=1 in the cycle after edge T+2.
- rsp_valid, rsp_rdata and rsp_err SHALL be held stable in RESP until the rsp_ready handshake.
REQ-020 Stores SHALL use these byte enables:
- SB (000): be=4'b0001<<a[1:0].
- SH (001): be=4'b0011<<a[1:0], legal only if a[0]=0.
- SW (010): be=4'b1111, legal only if a[1:0]=0.
REQ-021 Store write data SHALL be replicated across lanes (byte x4, half x2) and written with byte granularity at the ACCESS edge.
REQ-022 Loads SHALL select data from the word read in ACCESS as follows:
- LB (000) and LBU (100): lane a[1:0], sign-extended or zero-extended respectively.
- LH (001) and LHU (101): lane a[1], sign-extended or zero-extended respectively; legal only if a[0]=0.
- LW (010): legal only if a[1:0]=0.
REQ-023 Errored accesses SHALL be detected at acceptance and handled as follows:
- Error cases: misaligned accesses, load funct3 011/110/111, store funct3 other than 000-010.
- No memory write SHALL occur.
- The response SHALL carry rsp_err=1 and rsp_rdata=0, and err_cnt SHALL increment, saturating at 255.
REQ-024 The word index SHALL be req_addr[ADDR_W-1:2]; address wrap-around SHALL NOT occur since the index width exactly covers the depth.
REQ-025 A load following a store to the same word SHALL return the updated data, with no stale read.
REQ-026 A new request SHALL NOT be accepted in the same cycle as the rsp_ready handshake; req_ready rises the following cycle.

Reset
REQ-027 On rst_n=0 the block SHALL asynchronously force the following:
- state=IDLE, req_ready=1 after release.
- rsp_valid=0, rsp_rdata=0, rsp_err=0, err_cnt=0.
REQ-028 Memory contents SHALL NOT be reset.
REQ-029 A store whose ACCESS edge has not occurred when reset asserts SHALL be aborted with no write; an in-flight response SHALL be discarded.

Structure
REQ-030 Package lsu_pkg SHALL hold the following:
- The funct3 enum (LB, LH, LW, LBU, LHU, SB, SH, SW).
- The FSM state enum.
- The byte-enable and load-extend functions.
REQ-031 Sub-module lsu_sram SHALL be a word-addressed synchronous single-port RAM with 4-bit byte write enable and registered read.

Verification
REQ-032 The bench SHALL check: SW 0xDEADBEEF @0x010, then LW @0x010 -> rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid 2 cycles after accept.
REQ-033 The bench SHALL check: SB 0x80 @0x013, then LB @0x013 -> 0xFFFFFF80; LBU @0x013 -> 0x00000080; LW @0x010 -> 0x80ADBEEF.
REQ-034 The bench SHALL check: SH 0x1234 @0x011 -> rsp_err=1, rsp_rdata=0, err_cnt=1; LW @0x010 still returns 0x80ADBEEF.
REQ-035 The bench SHALL check: rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_rdata stable and req_ready=0 throughout.
REQ-036 The bench SHALL check: 300 illegal LW @0x001 requests -> err_cnt saturates at 255.
REQ-037 The bench SHALL check: SW 0xFFFFFFFF @0x020 with rst_n pulsed low during ACCESS-1 -> outputs zero, and a later LW @0x020 returns the prior value.
